// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//   Multi-digit BCD up/down counter with a programmable terminal value (TOP),
//   synchronous parallel load with validation, a registered wrap pulse and a
//   combinational terminal-count output for ripple-enable cascading.
//
// Parameters
//   DIGITS : number of BCD digits (1..8); Q/D are 4*DIGITS bits wide
//   TOP    : terminal count as a decimal integer (1..10^DIGITS-1)
//
// Ports
//   CLK    : rising-edge clock
//   CR     : synchronous active-high clear (highest priority)
//   EN     : count enable
//   UP     : direction, 1 = up, 0 = down
//   LD     : synchronous parallel load request (acts regardless of EN)
//   D      : BCD load value, digit k in D[4k+3:4k]
//   Q      : current count, BCD
//   CO     : registered one-cycle pulse after a wrap edge
//   TC     : combinational terminal count; drives the next stage's EN
//   LD_ERR : registered one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int TOP    = 59
) (
    input  logic                  CLK,
    input  logic                  CR,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CO,
    output logic                  TC,
    output logic                  LD_ERR
);

    localparam int W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Reject illegal parameter combinations at elaboration.
    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_updown_counter: DIGITS=%0d outside 1..8", DIGITS);
        end
        if (TOP < 1 || TOP > pow10(DIGITS) - 1) begin : g_bad_top
            $error("bcd_updown_counter: TOP=%0d outside 1..10^DIGITS-1", TOP);
        end
    endgenerate

    localparam logic [W-1:0] TOP_BCD = to_bcd(TOP);

    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] q_q, q_d;
    logic         co_q, co_d;
    logic         lderr_q, lderr_d;
    logic         load_ok;

    // With every digit valid, packed BCD orders the same as its decimal value,
    // so a plain unsigned compare against TOP_BCD is a decimal range check.
    assign load_ok = digits_ok(D) && (D <= TOP_BCD);

    always_comb begin
        q_d     = q_q;
        co_d    = 1'b0;
        lderr_d = 1'b0;
        if (LD) begin
            if (load_ok) begin
                q_d = D;
            end else begin
                lderr_d = 1'b1;
            end
        end else if (EN) begin
            if (UP) begin
                if (q_q == TOP_BCD) begin
                    q_d  = '0;
                    co_d = 1'b1;
                end else begin
                    q_d = bcd_inc(q_q);
                end
            end else begin
                if (q_q == '0) begin
                    q_d  = TOP_BCD;
                    co_d = 1'b1;
                end else begin
                    q_d = bcd_dec(q_q);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CR) begin
            q_q     <= '0;
            co_q    <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            co_q    <= co_d;
            lderr_q <= lderr_d;
        end
    end

    assign Q      = q_q;
    assign CO     = co_q;
    assign LD_ERR = lderr_q;

    // Zero-latency so a downstream stage advances on the same edge as this wrap.
    assign TC = EN & ~LD & ~CR & (UP ? (q_q == TOP_BCD) : (q_q == '0));

    // The count never leaves 0..TOP nor holds a non-BCD digit.
    a_in_range : assert property (@(posedge CLK) disable iff (CR)
        (digits_ok(q_q) && (q_q <= TOP_BCD)));

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic cr;

    // Main instance: DIGITS=2, TOP=59
    logic       en, up, ld;
    logic [7:0] d, q;
    logic       co, tc, lderr;

    // Cascade: seconds -> minutes
    logic       c_en, c_up, c_ld;
    logic [7:0] c_d, s_q, m_q;
    logic       s_co, s_tc, s_lderr, m_co, m_tc, m_lderr;

    // Three digits, TOP=999
    logic        t_en, t_up, t_ld;
    logic [11:0] t_d, t_q;
    logic        t_co, t_tc, t_lderr;

    // One digit, TOP=1 (back-to-back wraps)
    logic       b_en, b_up, b_ld;
    logic [3:0] b_d, b_q;
    logic       b_co, b_tc, b_lderr;

    int n_vec = 0;
    int n_err = 0;

    bcd_updown_counter #(.DIGITS(2), .TOP(59)) u_dut (
        .CLK(clk), .CR(cr), .EN(en), .UP(up), .LD(ld), .D(d),
        .Q(q), .CO(co), .TC(tc), .LD_ERR(lderr)
    );

    bcd_updown_counter #(.DIGITS(2), .TOP(59)) u_sec (
        .CLK(clk), .CR(cr), .EN(c_en), .UP(c_up), .LD(c_ld), .D(c_d),
        .Q(s_q), .CO(s_co), .TC(s_tc), .LD_ERR(s_lderr)
    );

    bcd_updown_counter #(.DIGITS(2), .TOP(59)) u_min (
        .CLK(clk), .CR(cr), .EN(s_tc), .UP(c_up), .LD(c_ld), .D(c_d),
        .Q(m_q), .CO(m_co), .TC(m_tc), .LD_ERR(m_lderr)
    );

    bcd_updown_counter #(.DIGITS(3), .TOP(999)) u_three (
        .CLK(clk), .CR(cr), .EN(t_en), .UP(t_up), .LD(t_ld), .D(t_d),
        .Q(t_q), .CO(t_co), .TC(t_tc), .LD_ERR(t_lderr)
    );

    bcd_updown_counter #(.DIGITS(1), .TOP(1)) u_one (
        .CLK(clk), .CR(cr), .EN(b_en), .UP(b_up), .LD(b_ld), .D(b_d),
        .Q(b_q), .CO(b_co), .TC(b_tc), .LD_ERR(b_lderr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [7:0] eq, input logic eco, input logic ele);
        check({tag, ".Q"},      32'(q),     32'(eq));
        check({tag, ".CO"},     32'(co),    32'(eco));
        check({tag, ".LD_ERR"}, 32'(lderr), 32'(ele));
    endtask

    initial begin
        cr = 1'b1;
        en = 1'b0; up = 1'b1; ld = 1'b0; d = 8'h00;
        c_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_d = 8'h00;
        t_en = 1'b0; t_up = 1'b1; t_ld = 1'b0; t_d = 12'h000;
        b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_d = 4'h0;
        tick();
        chk_main("rst0", 8'h00, 1'b0, 1'b0);
        check("rst0.TC", 32'(tc), 32'd0);

        // Reset overrides simultaneous LD and EN
        cr = 1'b0; ld = 1'b1; d = 8'h37;
        tick();
        chk_main("ld37", 8'h37, 1'b0, 1'b0);
        cr = 1'b1; en = 1'b1; ld = 1'b1; d = 8'h22;
        #1 check("tc_cr", 32'(tc), 32'd0);
        tick();
        chk_main("rst1", 8'h00, 1'b0, 1'b0);

        // Up wrap
        cr = 1'b0; en = 1'b0; ld = 1'b1; d = 8'h57;
        tick();
        chk_main("ld57", 8'h57, 1'b0, 1'b0);
        ld = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk_main("up58", 8'h58, 1'b0, 1'b0);
        check("tc58", 32'(tc), 32'd0);
        tick();
        chk_main("up59", 8'h59, 1'b0, 1'b0);
        check("tc59", 32'(tc), 32'd1);
        ld = 1'b1; d = 8'h59;
        #1 check("tc59_ld", 32'(tc), 32'd0);
        ld = 1'b0;
        en = 1'b0;
        #1 check("tc59_noen", 32'(tc), 32'd0);
        en = 1'b1;
        tick();
        chk_main("upwrap", 8'h00, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        chk_main("idle", 8'h00, 1'b0, 1'b0);

        // Down with BCD borrow, then down wrap
        ld = 1'b1; d = 8'h10;
        tick();
        ld = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        chk_main("dn09", 8'h09, 1'b0, 1'b0);
        ld = 1'b1; d = 8'h00;
        tick();
        chk_main("ld00", 8'h00, 1'b0, 1'b0);
        ld = 1'b0;
        #1 check("tc_dn0", 32'(tc), 32'd1);
        tick();
        chk_main("dnwrap", 8'h59, 1'b1, 1'b0);
        tick();
        chk_main("dn58", 8'h58, 1'b0, 1'b0);

        // Load validation
        en = 1'b0; ld = 1'b1; d = 8'h60;
        tick();
        chk_main("ld60", 8'h58, 1'b0, 1'b1);
        ld = 1'b0;
        tick();
        chk_main("lderr_clr", 8'h58, 1'b0, 1'b0);
        ld = 1'b1; d = 8'h3A;
        tick();
        chk_main("ld3A", 8'h58, 1'b0, 1'b1);
        d = 8'h42;
        tick();
        chk_main("ld42", 8'h42, 1'b0, 1'b0);
        en = 1'b1; up = 1'b1; d = 8'h99;
        tick();
        chk_main("ld99_en", 8'h42, 1'b0, 1'b1);
        en = 1'b0; d = 8'h59;
        tick();
        chk_main("ldtop", 8'h59, 1'b0, 1'b0);

        // Direction reversal every edge
        d = 8'h30;
        tick();
        ld = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk_main("rev31a", 8'h31, 1'b0, 1'b0);
        up = 1'b0;
        tick();
        chk_main("rev30a", 8'h30, 1'b0, 1'b0);
        up = 1'b1;
        tick();
        chk_main("rev31b", 8'h31, 1'b0, 1'b0);
        up = 1'b0;
        tick();
        chk_main("rev30b", 8'h30, 1'b0, 1'b0);
        en = 1'b0;

        // Cascade 59:59 -> 00:00 on one edge
        c_ld = 1'b1; c_d = 8'h59;
        tick();
        check("casc_ld_s", 32'(s_q), 32'h59);
        check("casc_ld_m", 32'(m_q), 32'h59);
        c_ld = 1'b0; c_en = 1'b1; c_up = 1'b1;
        #1 check("casc_tc_s", 32'(s_tc), 32'd1);
        tick();
        check("casc_s_q", 32'(s_q), 32'h00);
        check("casc_m_q", 32'(m_q), 32'h00);
        check("casc_s_co", 32'(s_co), 32'd1);
        check("casc_m_co", 32'(m_co), 32'd1);
        tick();
        check("casc_s_q1", 32'(s_q), 32'h01);
        check("casc_m_q1", 32'(m_q), 32'h00);
        check("casc_m_co1", 32'(m_co), 32'd0);
        c_en = 1'b0;

        // Three-digit carry/borrow chains
        t_ld = 1'b1; t_d = 12'h199;
        tick();
        t_ld = 1'b0; t_en = 1'b1; t_up = 1'b1;
        tick();
        check("three_inc", 32'(t_q), 32'h200);
        t_up = 1'b0;
        tick();
        check("three_dec", 32'(t_q), 32'h199);
        t_ld = 1'b1; t_d = 12'h999;
        tick();
        t_ld = 1'b0; t_up = 1'b1;
        tick();
        check("three_wrap", 32'(t_q), 32'h000);
        check("three_co", 32'(t_co), 32'd1);
        t_up = 1'b0;
        tick();
        check("three_dnwrap", 32'(t_q), 32'h999);
        t_en = 1'b0;

        // TOP=1: back-to-back wraps
        cr = 1'b1;
        tick();
        cr = 1'b0; b_en = 1'b1; b_up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("one_q%0d", i),  32'(b_q),  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("one_co%0d", i), 32'(b_co), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        b_ld = 1'b1; b_d = 4'h2;
        tick();
        check("one_ld2_err", 32'(b_lderr), 32'd1);
        check("one_ld2_co", 32'(b_co), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
